// File: rtl/vx_gpu_pkg.sv
// Shared commit/writeback record types and execution-unit source indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vx_gpu_pkg;

  localparam int NUM_THREADS = 4;
  localparam int XLEN        = 32;
  localparam int NW_BITS     = 2;
  localparam int NR_BITS     = 6;
  localparam int UUID_WIDTH  = 44;

  // Commit source indices within one issue slot
  localparam int EX_ALU = 0;
  localparam int EX_LSU = 1;
  localparam int EX_FPU = 2;
  localparam int EX_SFU = 3;
  localparam int EX_NUM = 4;

  typedef struct packed {
    logic [UUID_WIDTH-1:0]                uuid;
    logic [NW_BITS-1:0]                   wid;
    logic [NUM_THREADS-1:0]               tmask;
    logic [XLEN-1:0]                      pc;
    logic                                 wb;
    logic [NR_BITS-1:0]                   rd;
    logic [NUM_THREADS-1:0][XLEN-1:0]     data;
    logic                                 eop;
  } commit_t;

  typedef struct packed {
    logic [UUID_WIDTH-1:0]                uuid;
    logic [NW_BITS-1:0]                   wid;
    logic [NUM_THREADS-1:0]               tmask;
    logic [XLEN-1:0]                      pc;
    logic [NR_BITS-1:0]                   rd;
    logic [NUM_THREADS-1:0][XLEN-1:0]     data;
    logic                                 eop;
  } writeback_t;

  localparam int CW = $bits(commit_t);
  localparam int WW = $bits(writeback_t);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  // Drop the wb flag; every other field is forwarded untouched (tmask=0 included)
  function automatic writeback_t commit_to_wb(input commit_t c);
    writeback_t w;
    w.uuid  = c.uuid;
    w.wid   = c.wid;
    w.tmask = c.tmask;
    w.pc    = c.pc;
    w.rd    = c.rd;
    w.data  = c.data;
    w.eop   = c.eop;
    return w;
  endfunction

endpackage

// File: rtl/vx_commit_rr_arb.sv
// Round-robin picker: first requester at or after ptr, or the locked source only.
// Latency: combinational.
// Backpressure: none; grant is one-hot or zero.
module vx_commit_rr_arb #(
  parameter int NUM_SRC = 4,
  localparam int IW = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IW-1:0]      ptr,
  input  logic               lock,
  input  logic [IW-1:0]      lock_idx,
  output logic [NUM_SRC-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               grant_vld
);

  logic [IW-1:0] cand;

  // Locked: only the packet owner may be granted; otherwise rotate from ptr
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    if (lock) begin
      if (req[lock_idx]) begin
        grant_idx = lock_idx;
        grant_vld = 1'b1;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        cand = IW'((int'(ptr) + i) % NUM_SRC);
        if (!grant_vld && req[cand]) begin
          grant_idx = cand;
          grant_vld = 1'b1;
        end
      end
    end
    if (grant_vld) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/vx_commit_arbiter.sv
// Merges per-unit commit streams of one issue slot into one writeback stream; counts retires.
// Latency: 1 cycle from grant to wb_valid/wb_data.
// Backpressure: sources held by commit_ready (one-hot); writeback side has none.
module vx_commit_arbiter
  import vx_gpu_pkg::*;
#(
  parameter int NUM_SRC  = EX_NUM,
  parameter int CTR_BITS = 44
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_SRC-1:0]      commit_valid,
  output logic [NUM_SRC-1:0]      commit_ready,
  input  logic [NUM_SRC*CW-1:0]   commit_data,
  output logic                    wb_valid,
  output logic [WW-1:0]           wb_data,
  output logic [CTR_BITS-1:0]     retired_cnt
);

  localparam int IW = $clog2(NUM_SRC);

  commit_t           src [NUM_SRC];
  commit_t           sel;
  logic [NUM_SRC-1:0] arb_grant;
  logic              arb_vld;
  logic              grant_vld;
  logic [IW-1:0]     grant_idx;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     lock_idx;
  logic              lock;
  lock_state_e       state;
  lock_state_e       state_nxt;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign src[i] = commit_t'(commit_data[i*CW +: CW]);
  end

  vx_commit_rr_arb #(
    .NUM_SRC (NUM_SRC)
  ) u_arb (
    .req       (commit_valid),
    .ptr       (ptr),
    .lock      (lock),
    .lock_idx  (lock_idx),
    .grant     (arb_grant),
    .grant_idx (grant_idx),
    .grant_vld (arb_vld)
  );

  // Nothing is accepted while reset is held, so sources never see a handshake that gets lost
  assign commit_ready = reset ? arb_grant : '0;
  assign grant_vld    = arb_vld & reset;
  assign sel          = src[grant_idx];

  // Lock state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Enter lock on a non-final beat, leave it when the final beat is accepted
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (grant_vld && !sel.eop) state_nxt = ST_LOCKED;
      ST_LOCKED: if (grant_vld &&  sel.eop) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Arbiter restriction driven by the lock state
  always_comb begin
    lock = (state == ST_LOCKED);
  end

  // Rotation pointer moves past each granted source; lock owner is the last granted source
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr      <= '0;
      lock_idx <= '0;
    end else if (grant_vld) begin
      ptr      <= (grant_idx == IW'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
      lock_idx <= grant_idx;
    end
  end

  // Writeback register: data only updates on a writing commit, otherwise holds
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
    end else begin
      wb_valid <= grant_vld & sel.wb;
      if (grant_vld && sel.wb) wb_data <= commit_to_wb(sel);
    end
  end

  // Retire counter: one per accepted final beat, wraps naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  retired_cnt <= '0;
    else if (grant_vld && sel.eop) retired_cnt <= retired_cnt + CTR_BITS'(1);
  end

endmodule

// File: tb/tb_vx_commit_arbiter.sv
module tb_vx_commit_arbiter;
  import vx_gpu_pkg::*;

  logic             clk;
  logic             reset;
  logic [3:0]       commit_valid;
  logic [3:0]       commit_ready;
  logic [4*CW-1:0]  commit_data;
  logic             wb_valid;
  logic [WW-1:0]    wb_data;
  logic [43:0]      retired_cnt;

  // Narrow-counter instance for the wrap check
  logic [3:0]       v2;
  logic [3:0]       rdy2;
  logic [4*CW-1:0]  data2;
  logic             wbv2;
  logic [WW-1:0]    wbd2;
  logic [1:0]       r2;

  commit_t          cd [4];
  commit_t          d2;
  logic [3:0]       cv;

  writeback_t       sbq [$];
  writeback_t       last_wb;
  logic             exp_wbv;
  logic [43:0]      exp_ret;
  logic [1:0]       exp2;
  int               checks;
  int               failures;
  int               sq [4];

  for (genvar i = 0; i < 4; i++) begin : g_pack
    assign commit_data[i*CW +: CW] = cd[i];
    assign data2[i*CW +: CW]       = (i == 0) ? d2 : '0;
  end
  assign commit_valid = cv;

  vx_commit_arbiter #(.NUM_SRC(4), .CTR_BITS(44)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .commit_valid (commit_valid),
    .commit_ready (commit_ready),
    .commit_data  (commit_data),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .retired_cnt  (retired_cnt)
  );

  vx_commit_arbiter #(.NUM_SRC(4), .CTR_BITS(2)) u_dut_w (
    .clk          (clk),
    .reset        (reset),
    .commit_valid (v2),
    .commit_ready (rdy2),
    .commit_data  (data2),
    .wb_valid     (wbv2),
    .wb_data      (wbd2),
    .retired_cnt  (r2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic commit_t mk(input int s, input int seq, input logic wb, input logic eop);
    commit_t c;
    c.uuid  = 44'(seq * 16 + s);
    c.wid   = 2'(s);
    c.tmask = 4'(seq);
    c.pc    = 32'h1000 + 32'(seq * 4);
    c.wb    = wb;
    c.rd    = 6'(seq);
    for (int l = 0; l < 4; l++) c.data[l] = {8'(s), 8'(l), 16'(seq)};
    c.eop   = eop;
    return c;
  endfunction

  function automatic writeback_t to_wb(input commit_t c);
    writeback_t w;
    w = '{uuid: c.uuid, wid: c.wid, tmask: c.tmask, pc: c.pc, rd: c.rd, data: c.data, eop: c.eop};
    return w;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Check the ready vector for the currently driven inputs and record what it implies
  task automatic expect_grant(input logic [3:0] exp_g);
    #1;
    chk("ready", 256'(commit_ready), 256'(exp_g));
    for (int i = 0; i < 4; i++) begin
      if (exp_g[i]) begin
        if (cd[i].wb) begin
          sbq.push_back(to_wb(cd[i]));
          exp_wbv = 1'b1;
        end
        if (cd[i].eop) exp_ret++;
      end
    end
  endtask

  // Advance one clock and compare registered outputs against the scoreboard
  task automatic tick();
    writeback_t w;
    @(posedge clk);
    #1;
    chk("wb_valid", 256'(wb_valid), 256'(exp_wbv));
    if (wb_valid && sbq.size() > 0) begin
      w = sbq.pop_front();
      chk("wb_data", 256'(wb_data), 256'(w));
      last_wb = w;
    end
    chk("retired", 256'(retired_cnt), 256'(exp_ret));
    exp_wbv = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_wbv  = 1'b0;
    exp_ret  = '0;
    exp2     = '0;
    last_wb  = '0;
    v2       = '0;
    d2       = '0;
    for (int i = 0; i < 4; i++) cd[i] = mk(i, i, 1'b1, 1'b1);

    // Reset state, with all sources requesting
    reset = 1'b0;
    cv    = 4'b1111;
    #2;
    chk("rst_ready", 256'(commit_ready), 256'(0));
    chk("rst_wb_valid", 256'(wb_valid), 256'(0));
    chk("rst_wb_data", 256'(wb_data), 256'(0));
    chk("rst_retired", 256'(retired_cnt), 256'(0));
    cv = 4'b0000;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // 1: single ALU commit
    cd[0]      = mk(0, 1, 1'b1, 1'b1);
    cd[0].rd   = 6'd5;
    cd[0].data = {4{32'hDEAD_BEEF}};
    cv = 4'b0001;
    expect_grant(4'b0001);
    tick();
    chk("t1_rd", 256'(wb_data[WW-1-44-2-4-32 -: 6]), 256'(5));
    chk("t1_retired", 256'(retired_cnt), 256'(1));
    cv = 4'b0000;
    expect_grant(4'b0000);
    tick();
    chk("t1_hold", 256'(wb_data), 256'(last_wb));

    // 2: all valid for 8 cycles from ptr=0
    reset = 1'b0;
    #1;
    reset   = 1'b1;
    exp_ret = '0;
    for (int i = 0; i < 4; i++) begin
      sq[i] = 16 + i * 20;
      cd[i] = mk(i, sq[i], 1'b1, 1'b1);
    end
    cv = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      expect_grant(4'b0001 << (k % 4));
      tick();
      sq[k % 4]++;
      cd[k % 4] = mk(k % 4, sq[k % 4], 1'b1, 1'b1);
    end
    cv = 4'b0000;
    chk("t2_retired", 256'(retired_cnt), 256'(8));

    // 3: LSU three-beat packet with ALU waiting, including an LSU valid gap
    cd[1] = mk(1, 200, 1'b1, 1'b0);
    cv = 4'b0010;
    expect_grant(4'b0010);
    tick();
    cd[1] = mk(1, 201, 1'b1, 1'b0);
    cd[0] = mk(0, 210, 1'b1, 1'b1);
    cv = 4'b0011;
    expect_grant(4'b0010);
    tick();
    cv = 4'b0001;
    expect_grant(4'b0000);
    tick();
    cd[1] = mk(1, 202, 1'b1, 1'b1);
    cv = 4'b0011;
    expect_grant(4'b0010);
    tick();
    cv = 4'b0001;
    expect_grant(4'b0001);
    tick();
    cv = 4'b0000;

    // 4: SFU commit without writeback still retires
    cd[3] = mk(3, 300, 1'b0, 1'b1);
    cv = 4'b1000;
    expect_grant(4'b1000);
    tick();
    chk("t4_no_wb", 256'(wb_valid), 256'(0));
    cv = 4'b0000;

    // 5: reset in the second beat of a locked FPU packet
    cd[2] = mk(2, 400, 1'b1, 1'b0);
    cv = 4'b0100;
    expect_grant(4'b0100);
    tick();
    cd[2] = mk(2, 401, 1'b1, 1'b0);
    cd[0] = mk(0, 410, 1'b1, 1'b1);
    cv = 4'b0101;
    #1;
    chk("t5_locked_ready", 256'(commit_ready), 256'(4'b0100));
    reset = 1'b0;
    #1;
    chk("t5_rst_ready", 256'(commit_ready), 256'(0));
    chk("t5_rst_wb_valid", 256'(wb_valid), 256'(0));
    chk("t5_rst_wb_data", 256'(wb_data), 256'(0));
    chk("t5_rst_retired", 256'(retired_cnt), 256'(0));
    sbq.delete();
    exp_wbv = 1'b0;
    exp_ret = '0;
    tick();
    reset = 1'b1;
    cd[2] = mk(2, 402, 1'b1, 1'b1);
    cd[3] = mk(3, 420, 1'b1, 1'b1);
    cv = 4'b1100;
    expect_grant(4'b0100);
    tick();
    cv = 4'b1000;
    expect_grant(4'b1000);
    tick();
    cv = 4'b0000;

    // 6: narrow counter reaches all-ones then wraps to zero
    d2 = mk(0, 500, 1'b1, 1'b1);
    v2 = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t6_ready", 256'(rdy2), 256'(4'b0001));
      tick();
      exp2 = exp2 + 2'd1;
      chk("t6_cnt", 256'(r2), 256'(exp2));
    end
    v2 = 4'b0000;
    chk("t6_wrapped", 256'(r2), 256'(0));

    chk("sb_empty", 256'(sbq.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
